vga_pixel_pipe: RTL and testbench

- Sits between `vga_controller` and the VGA pins.
- Turns controller counters into read addresses for the 320x240 8-bit grayscale/edge frame buffer and pipelines the returned pixel into 12-bit RGB.
- Re-aligns hsync/vsync/display-enable to that pixel.
- Applies 2x upscaling, per-frame display-mode latching and a double-buffer swap handshake with the Sobel engine.

---
 rtl/sobel_vga_pkg.sv | 35 +++
 rtl/pipe_delay.sv | 27 ++
 rtl/vga_pixel_pipe.sv | 162 ++++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_vga_pkg.sv
// Shared constants and types for the Sobel/VGA display path.
// Holds 640x480@60 timing, frame-buffer image size and display-mode encodings.
package sobel_vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  typedef enum logic [1:0] {
    MODE_GRAY   = 2'b00,
    MODE_THRESH = 2'b01,
    MODE_INV    = 2'b10,
    MODE_BARS   = 2'b11
  } disp_mode_t;

  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_WHITE = 12'hFFF;

  // Replicates a 4-bit intensity onto all three colour channels.
  function automatic logic [11:0] gray_rgb(input logic [3:0] nib);
    return {nib, nib, nib};
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with synchronous active-low reset.
// Every stage resets to RST_VAL so a flushed line never emits stale data.
module pipe_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipe.sv
// Frame-buffer read addressing, pixel colour mapping and sync realignment
// between vga_controller and the VGA pins, with 2x upscale and buffer swap.
module vga_pixel_pipe
  import sobel_vga_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              de_in,
  input  logic [1:0]        mode,
  input  logic [7:0]        threshold,
  input  logic              swap_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_sel,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [11:0]       rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              swap_ack,
  output logic              frame_start
);

  // ---------------------------------------------------------------------
  // Address stage: 2x upscale drops the counter LSBs. The row multiply by
  // 320 is built from two shifts (256 + 64) so it stays in plain adders.
  // ---------------------------------------------------------------------
  logic [8:0]        row;
  logic [9:0]        col;
  logic              in_active;
  logic [ADDR_W-1:0] addr_next;
  logic [2:0]        bar_q;
  logic              unused_lsb;

  assign row        = v_cnt[9:1];
  assign col        = h_cnt[10:1];
  assign in_active  = (h_cnt < 11'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign addr_next  = ADDR_W'({row, 8'b0}) + ADDR_W'({row, 6'b0}) + ADDR_W'(col);
  assign unused_lsb = ^{h_cnt[0], v_cnt[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_en   <= 1'b0;
      bar_q   <= 3'd0;
    end else begin
      rd_addr <= in_active ? addr_next : '0;
      rd_en   <= in_active;
      bar_q   <= h_cnt[8:6];
    end
  end

  // ---------------------------------------------------------------------
  // Sideband delay: the controller's syncs already lag the counters by one
  // cycle, matching bar_q. RD_LAT stages here plus the output register
  // below give RD_LAT+1 total, landing them on the same cycle as rgb.
  // RD_LAT must be at least 1.
  // ---------------------------------------------------------------------
  localparam int               SB_W   = 6;
  localparam logic [SB_W-1:0]  SB_RST = {1'b1, 1'b1, 1'b0, 3'd0};

  logic [SB_W-1:0] sb_in;
  logic [SB_W-1:0] sb_out;
  logic            dly_hs;
  logic            dly_vs;
  logic            dly_de;
  logic [2:0]      dly_bar;

  assign sb_in = {hsync_in, vsync_in, de_in, bar_q};

  pipe_delay #(
    .WIDTH   (SB_W),
    .DEPTH   (RD_LAT),
    .RST_VAL (SB_RST)
  ) u_sb_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sb_in),
    .dout  (sb_out)
  );

  assign {dly_hs, dly_vs, dly_de, dly_bar} = sb_out;

  // ---------------------------------------------------------------------
  // Frame boundary = vsync_in falling edge. Mode/threshold are latched
  // only here so a frame is always rendered with one consistent setting.
  // Swap handshake: swap_req is a level owned by the Sobel engine; it is
  // sampled only on the boundary cycle, the swap is applied and swap_ack
  // pulses for one cycle, and the engine must drop swap_req on swap_ack
  // or the buffers flip again at the following boundary.
  // ---------------------------------------------------------------------
  logic       vs_prev;
  logic       vs_fall;
  disp_mode_t mode_q;
  logic [7:0] thr_q;

  assign vs_fall = vs_prev & ~vsync_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_prev     <= 1'b1;
      mode_q      <= MODE_GRAY;
      thr_q       <= 8'd0;
      rd_sel      <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vs_prev     <= vsync_in;
      frame_start <= vs_fall;
      swap_ack    <= vs_fall & swap_req;
      if (vs_fall) begin
        mode_q <= disp_mode_t'(mode);
        thr_q  <= threshold;
        if (swap_req) rd_sel <= ~rd_sel;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pixel stage: colour map the returned pixel, blank outside active video.
  // ---------------------------------------------------------------------
  logic [3:0]  nib;
  logic [11:0] pix_next;

  assign nib = rd_data[DATA_W-1 -: 4];

  always_comb begin
    pix_next = RGB_BLACK;
    case (mode_q)
      MODE_GRAY:   pix_next = gray_rgb(nib);
      MODE_THRESH: pix_next = (rd_data >= DATA_W'(thr_q)) ? RGB_WHITE : RGB_BLACK;
      MODE_INV:    pix_next = gray_rgb(~nib);
      MODE_BARS:   pix_next = {{4{dly_bar[2]}}, {4{dly_bar[1]}}, {4{dly_bar[0]}}};
      default:     pix_next = RGB_BLACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb   <= RGB_BLACK;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
    end else begin
      rgb   <= dly_de ? pix_next : RGB_BLACK;
      hsync <= dly_hs;
      vsync <= dly_vs;
      de    <= dly_de;
    end
  end

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Self-checking bench for vga_pixel_pipe: directed scans plus random counters
// and syncs, compared every cycle against a cycle-history reference model.
module tb_vga_pixel_pipe;

  localparam int RD_LAT = 2;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int N      = 4096;

  // clock / reset
  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic              rst_n;
  logic [10:0]       h_cnt;
  logic [9:0]        v_cnt;
  logic              hsync_in, vsync_in, de_in;
  logic [1:0]        mode;
  logic [7:0]        threshold;
  logic              swap_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_sel, rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [11:0]       rgb;
  logic              hsync, vsync, de, swap_ack, frame_start;

  vga_pixel_pipe #(
    .IMG_W(320), .IMG_H(240), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .mode(mode), .threshold(threshold), .swap_req(swap_req),
    .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_en(rd_en), .rd_data(rd_data),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de),
    .swap_ack(swap_ack), .frame_start(frame_start)
  );

  // frame-buffer model: content depends on address and selected buffer
  function automatic logic [7:0] mem_f(input int a, input bit s);
    logic [31:0] av;
    av = a;
    return av[7:0] ^ (s ? 8'hA5 : 8'h00);
  endfunction

  logic [7:0] m1 = 8'h00, m2 = 8'h00;
  always @(posedge clk) begin
    m1 <= mem_f(int'(rd_addr), rd_sel);
    m2 <= m1;
  end
  assign rd_data = m2;

  // stimulus history (index = cycle) and model state
  int a_h[N], a_v[N], a_mode[N], a_thr[N];
  bit a_hs[N], a_vs[N], a_de[N], a_sw[N], a_rn[N];
  int e_addr[N], e_mode[N], e_thr[N];
  bit e_en[N], e_sel[N];
  bit x_hs, x_vs, x_de, x_sa, x_fs;
  int x_rgb;

  int  cyc = 0;
  int  n_checks = 0, n_errors = 0;
  bit  sw_level = 1'b0, drop_on_ack = 1'b0;

  function automatic bit rst_at(input int k);
    return (k < 0) || !a_rn[k];
  endfunction

  function automatic bit window_clear(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) if (rst_at(k)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit fall_at(input int k);
    bit prev;
    if (k < 0) return 1'b0;
    prev = (k < 1 || rst_at(k - 1)) ? 1'b1 : a_vs[k-1];
    return prev && !a_vs[k];
  endfunction

  // Expected outputs for cycle c from the rules applied to inputs of earlier cycles.
  task automatic model_step(input int c);
    int k, t, p, nib, bar;
    bit f;
    k = c - 1;
    if (rst_at(k)) begin
      e_addr[c] = 0; e_en[c] = 0; e_sel[c] = 0; e_mode[c] = 0; e_thr[c] = 0;
      x_sa = 0; x_fs = 0;
    end else begin
      if (a_h[k] < 640 && a_v[k] < 480) begin
        e_addr[c] = (a_v[k] / 2) * 320 + a_h[k] / 2;
        e_en[c]   = 1;
      end else begin
        e_addr[c] = 0;
        e_en[c]   = 0;
      end
      f = fall_at(k);
      x_fs = f;
      x_sa = f && a_sw[k];
      e_sel[c]  = e_sel[k] ^ x_sa;
      e_mode[c] = f ? a_mode[k] : e_mode[k];
      e_thr[c]  = f ? a_thr[k]  : e_thr[k];
    end
    if (window_clear(c - 1 - RD_LAT, c - 1)) begin
      x_hs = a_hs[c-1-RD_LAT]; x_vs = a_vs[c-1-RD_LAT]; x_de = a_de[c-1-RD_LAT];
    end else begin
      x_hs = 1; x_vs = 1; x_de = 0;
    end
    x_rgb = 0;
    if (x_de) begin
      t   = c - 2 - RD_LAT;
      p   = int'(mem_f(e_addr[t+1], e_sel[t+1]));
      bar = 0;
      if (!rst_at(t)) bar = (a_h[t] / 64) % 8;
      nib = p / 16;
      case (e_mode[c-1])
        0: x_rgb = nib * 273;
        1: x_rgb = (p >= e_thr[c-1]) ? 'hFFF : 0;
        2: x_rgb = (15 - nib) * 273;
        default: x_rgb = ((bar / 4) % 2) * 'hF00 + ((bar / 2) % 2) * 'h0F0 + (bar % 2) * 'h00F;
      endcase
    end
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      model_step(cyc);
      check("rd_addr", 32'(rd_addr), 32'(e_addr[cyc]));
      check("rd_en", 32'(rd_en), 32'(e_en[cyc]));
      check("rd_sel", 32'(rd_sel), 32'(e_sel[cyc]));
      check("rgb", 32'(rgb), 32'(x_rgb));
      check("hsync", 32'(hsync), 32'(x_hs));
      check("vsync", 32'(vsync), 32'(x_vs));
      check("de", 32'(de), 32'(x_de));
      check("swap_ack", 32'(swap_ack), 32'(x_sa));
      check("frame_start", 32'(frame_start), 32'(x_fs));
    end
  end

  // driver tasks
  task automatic record(input int c);
    a_h[c] = int'(h_cnt); a_v[c] = int'(v_cnt);
    a_hs[c] = hsync_in; a_vs[c] = vsync_in; a_de[c] = de_in;
    a_mode[c] = int'(mode); a_thr[c] = int'(threshold);
    a_sw[c] = swap_req; a_rn[c] = rst_n;
  endtask

  task automatic drive(input int h, input int v, input bit hs, input bit vs, input bit d,
                       input int md, input int th, input bit rn);
    @(posedge clk);
    #1;
    if (drop_on_ack && swap_ack) sw_level = 1'b0;
    if (cyc < N - 1) cyc++;
    h_cnt = 11'(h); v_cnt = 10'(v);
    hsync_in = hs; vsync_in = vs; de_in = d;
    mode = 2'(md); threshold = 8'(th);
    swap_req = sw_level; rst_n = rn;
    record(cyc);
  endtask

  task automatic scan(input int v, input int h0, input int h1, input int md, input int th);
    for (int h = h0; h <= h1; h++)
      drive(h, v, !(h >= 656 && h < 752), 1'b1, (h < 640 && v < 480), md, th, 1'b1);
  endtask

  task automatic vblank(input int md, input int th);
    for (int i = 0; i < 8; i++)
      drive($urandom_range(0, 799), 490 + i / 4, 1'b1, !(i >= 2 && i < 5), 1'b0, md, th, 1'b1);
  endtask

  initial begin
    rst_n = 0; h_cnt = 0; v_cnt = 0; hsync_in = 1; vsync_in = 1; de_in = 0;
    mode = 0; threshold = 0; swap_req = 0;
    record(0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);

    // gray mode: address corners then a full line
    vblank(0, 0);
    drive(2, 3, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
    drive(639, 479, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
    drive(640, 0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
    scan(0, 0, 700, 0, 0);

    // threshold latched at boundary, mid-frame changes ignored
    vblank(1, 8'h80);
    scan(0, 250, 262, 1, 8'h80);
    scan(0, 250, 262, 2, 8'h10);
    vblank(1, 8'h10);
    scan(0, 10, 40, 1, 8'h10);

    // single swap with drop-on-ack, colour bars
    sw_level = 1; drop_on_ack = 1;
    vblank(3, 0);
    scan(10, 0, 640, 3, 0);

    // swap held across two frames, inverted gray
    sw_level = 1; drop_on_ack = 0;
    vblank(2, 0);
    scan(12, 100, 160, 2, 0);
    vblank(2, 0);
    sw_level = 0;
    scan(14, 100, 160, 2, 0);

    // reset mid-line
    scan(20, 250, 299, 2, 0);
    for (int i = 0; i < 3; i++)
      drive(300 + i, 20, 1'b1, 1'b1, 1'b1, 2, 0, 1'b0);
    scan(20, 303, 380, 2, 0);

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      sw_level = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 799), $urandom_range(0, 524),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) != 0),
            ($urandom_range(0, 2) != 0), $urandom_range(0, 3), $urandom_range(0, 255),
            ($urandom_range(0, 299) != 0));
    end
    sw_level = 0;
    for (int i = 0; i < 6; i++) drive(700, 500, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
